// File: rtl/knight_anim_pkg.sv
// Shared types and geometry for the knight sprite strip: state encoding,
// default sprite dimensions and the ROM address helper.
package knight_anim_pkg;

   localparam int SPR_W           = 50;
   localparam int SPR_H           = 64;
   localparam int NUM_FRAMES      = 4;
   localparam int TICKS_PER_FRAME = 6;
   localparam int ADDR_W          = 14;
   localparam int FRAME_WORDS     = SPR_W * SPR_H;
   localparam int FRAME_IDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, HOLD} anim_state_t;

   // Frames are stored back-to-back, each one row-major.
   function automatic int unsigned calc_addr(input int unsigned frame,
                                             input int unsigned dx,
                                             input int unsigned dy,
                                             input int unsigned spr_w = SPR_W,
                                             input int unsigned spr_h = SPR_H);
      return frame * (spr_w * spr_h) + dy * spr_w + dx;
   endfunction

endpackage

// File: rtl/knight_anim_ctrl_if.sv
// Video timing, placement and animation-control signals between the VGA
// side and the knight sequencer, with its ROM address/coverage results.
interface knight_anim_ctrl_if #(
   parameter int ADDR_W = knight_anim_pkg::ADDR_W,
   parameter int FI_W   = knight_anim_pkg::FRAME_IDX_W
);
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic              blank;
   logic              vsync;
   logic [9:0]        sprite_x;
   logic [9:0]        sprite_y;
   logic              anim_start;
   logic              anim_loop;
   logic [ADDR_W-1:0] rom_address;
   logic              pix_valid;
   logic [FI_W-1:0]   frame_idx;
   logic              anim_busy;
   logic              anim_done;

   modport master (
      output DrawX, DrawY, blank, vsync, sprite_x, sprite_y, anim_start, anim_loop,
      input  rom_address, pix_valid, frame_idx, anim_busy, anim_done
   );

   modport slave (
      input  DrawX, DrawY, blank, vsync, sprite_x, sprite_y, anim_start, anim_loop,
      output rom_address, pix_valid, frame_idx, anim_busy, anim_done
   );
endinterface

// File: rtl/anim_addr_gen.sv
// Sprite box test and ROM address register for one palettized sprite strip;
// reusable by any sprite sharing the same ROM layout.
module anim_addr_gen #(
   parameter int SPR_W  = knight_anim_pkg::SPR_W,
   parameter int SPR_H  = knight_anim_pkg::SPR_H,
   parameter int ADDR_W = knight_anim_pkg::ADDR_W,
   parameter int FI_W   = knight_anim_pkg::FRAME_IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        draw_x,
   input  logic [9:0]        draw_y,
   input  logic              blank,
   input  logic [9:0]        org_x,
   input  logic [9:0]        org_y,
   input  logic [FI_W-1:0]   frame,
   output logic [ADDR_W-1:0] rom_address,
   output logic              pix_valid
);
   import knight_anim_pkg::*;

   localparam logic [10:0] BOX_W = 11'(SPR_W);
   localparam logic [10:0] BOX_H = 11'(SPR_H);

   logic [10:0] dx_p0;
   logic [10:0] dy_p0;
   logic        in_box_p0;

   // Bit 10 is the borrow: pixel lies left of / above the sprite origin.
   assign dx_p0     = {1'b0, draw_x} - {1'b0, org_x};
   assign dy_p0     = {1'b0, draw_y} - {1'b0, org_y};
   assign in_box_p0 = ~dx_p0[10] & ~dy_p0[10] & (dx_p0 < BOX_W) & (dy_p0 < BOX_H);

   // Stage p0 -> p1: address holds outside the box so the ROM output stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_address <= '0;
         pix_valid   <= 1'b0;
      end else begin
         if (in_box_p0)
            rom_address <= ADDR_W'(calc_addr(32'(frame), 32'(dx_p0), 32'(dy_p0), SPR_W, SPR_H));
         pix_valid <= in_box_p0 & blank;
      end
   end

endmodule

// File: rtl/knight_anim_ctrl.sv
// Knight sprite animation sequencer: steps frames on vsync boundaries,
// latches placement once per frame and drives the ROM address generator.
module knight_anim_ctrl #(
   parameter int SPR_W           = knight_anim_pkg::SPR_W,
   parameter int SPR_H           = knight_anim_pkg::SPR_H,
   parameter int NUM_FRAMES      = knight_anim_pkg::NUM_FRAMES,
   parameter int TICKS_PER_FRAME = knight_anim_pkg::TICKS_PER_FRAME,
   parameter int ADDR_W          = knight_anim_pkg::ADDR_W
) (
   input logic                vga_clk,
   input logic                reset_n,
   knight_anim_ctrl_if.slave  bus
);
   import knight_anim_pkg::*;

   localparam int FI_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
   localparam logic [FI_W-1:0]   FRAME_LAST = FI_W'(NUM_FRAMES - 1);

   anim_state_t       state;
   logic [TICK_W-1:0] tick;
   logic [FI_W-1:0]   frame;
   logic [9:0]        lat_x;
   logic [9:0]        lat_y;
   logic              vsync_q;
   logic              start_pending;
   logic              busy;
   logic              done;
   logic              fb;
   logic              start_req;

   assign fb        = bus.vsync & ~vsync_q;
   // A start arriving on the boundary cycle itself is honoured at that boundary.
   assign start_req = start_pending | bus.anim_start;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         tick          <= '0;
         frame         <= '0;
         lat_x         <= '0;
         lat_y         <= '0;
         vsync_q       <= 1'b0;
         start_pending <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         vsync_q <= bus.vsync;
         done    <= 1'b0;
         if (fb) begin
            start_pending <= 1'b0;
            lat_x         <= bus.sprite_x;
            lat_y         <= bus.sprite_y;
            if (start_req) begin
               state <= PLAY;
               busy  <= 1'b1;
               frame <= '0;
               tick  <= '0;
            end else if (state == PLAY) begin
               if (tick != TICK_LAST) begin
                  tick <= tick + TICK_W'(1);
               end else begin
                  tick <= '0;
                  if (frame != FRAME_LAST) begin
                     frame <= frame + FI_W'(1);
                  end else if (bus.anim_loop) begin
                     frame <= '0;
                  end else begin
                     state <= HOLD;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
         end else if (bus.anim_start) begin
            start_pending <= 1'b1;
         end
      end
   end

   assign bus.frame_idx = frame;
   assign bus.anim_busy = busy;
   assign bus.anim_done = done;

   anim_addr_gen #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .ADDR_W (ADDR_W),
      .FI_W   (FI_W)
   ) u_addr_gen (
      .clk         (vga_clk),
      .rst_n       (reset_n),
      .draw_x      (bus.DrawX),
      .draw_y      (bus.DrawY),
      .blank       (bus.blank),
      .org_x       (lat_x),
      .org_y       (lat_y),
      .frame       (frame),
      .rom_address (bus.rom_address),
      .pix_valid   (bus.pix_valid)
   );

endmodule

// File: tb/tb_knight_anim_ctrl.sv
// Randomized bench for knight_anim_ctrl against an elapsed-frame-count model
// of the animation plus a plain-arithmetic model of the sprite box.
module tb_knight_anim_ctrl;

   localparam int N = 4;
   localparam int T = 6;
   localparam int W = 50;
   localparam int H = 64;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;

   knight_anim_ctrl_if bus ();

   knight_anim_ctrl dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: m_el counts frame boundaries since the last (re)start.
   bit m_play, m_hold, m_pend, m_vq, m_pv, m_done;
   int m_el, m_lx, m_ly, m_rom;
   int done_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_frame();
      if (m_play || m_hold) return m_el / T;
      return 0;
   endfunction

   task automatic model_reset();
      m_play = 0; m_hold = 0; m_pend = 0; m_vq = 0; m_pv = 0; m_done = 0;
      m_el = 0; m_lx = 0; m_ly = 0; m_rom = 0;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_rom"},   32'(bus.rom_address), 0);
      check({pfx, "_pv"},    32'(bus.pix_valid),   0);
      check({pfx, "_frame"}, 32'(bus.frame_idx),   0);
      check({pfx, "_busy"},  32'(bus.anim_busy),   0);
      check({pfx, "_done"},  32'(bus.anim_done),   0);
   endtask

   task automatic step();
      int dx, dy;
      bit fb, in_box;
      fb     = bus.vsync && !m_vq;
      dx     = int'(bus.DrawX) - m_lx;
      dy     = int'(bus.DrawY) - m_ly;
      in_box = (dx >= 0) && (dx < W) && (dy >= 0) && (dy < H);
      if (in_box) m_rom = exp_frame() * W * H + dy * W + dx;
      m_pv   = in_box && bus.blank;
      m_done = 0;
      if (fb) begin
         if (m_pend || bus.anim_start) begin
            m_play = 1; m_hold = 0; m_el = 0;
         end else if (m_play) begin
            m_el++;
            if (m_el == N * T) begin
               if (bus.anim_loop) m_el = 0;
               else begin
                  m_play = 0; m_hold = 1; m_el = N * T - 1; m_done = 1;
               end
            end
         end
         m_lx = int'(bus.sprite_x);
         m_ly = int'(bus.sprite_y);
         m_pend = 0;
      end else if (bus.anim_start) begin
         m_pend = 1;
      end
      m_vq = bus.vsync;
      @(posedge vga_clk);
      #1;
      bus.anim_start = 1'b0;
      done_seen += int'(bus.anim_done);
      check("frame_idx",   32'(bus.frame_idx),   32'(exp_frame()));
      check("anim_busy",   32'(bus.anim_busy),   32'(m_play));
      check("anim_done",   32'(bus.anim_done),   32'(m_done));
      check("pix_valid",   32'(bus.pix_valid),   32'(m_pv));
      check("rom_address", 32'(bus.rom_address), 32'(m_rom));
   endtask

   task automatic rand_pix();
      int x, y;
      if ($urandom_range(0, 3) == 0) begin
         x = $urandom_range(0, 639);
         y = $urandom_range(0, 479);
      end else begin
         x = m_lx - 4 + $urandom_range(0, 58);
         y = m_ly - 4 + $urandom_range(0, 72);
      end
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      bus.blank = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
         bus.sprite_x = 10'($urandom_range(0, 639));
         bus.sprite_y = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 39) == 0) bus.anim_start = 1'b1;
      if ($urandom_range(0, 7) == 0)  bus.anim_loop  = ~bus.anim_loop;
   endtask

   task automatic vframe(input int npix, input bit rnd);
      bus.vsync = 1'b1;
      step();
      bus.vsync = 1'b0;
      repeat (npix) begin
         if (rnd) rand_pix();
         step();
      end
   endtask

   task automatic pix(input int x, input int y, input bit b);
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      bus.blank = b;
      step();
   endtask

   initial begin
      bus.DrawX = 10'd320; bus.DrawY = 10'd100; bus.blank = 1'b1; bus.vsync = 1'b0;
      bus.sprite_x = '0; bus.sprite_y = '0; bus.anim_start = 1'b0; bus.anim_loop = 1'b0;
      model_reset();
      done_seen = 0;
      #2;
      check_all_zero("reset");
      @(negedge vga_clk);
      reset_n = 1'b1;
      repeat (3) vframe(3, 0);
      check("idle_frame", 32'(bus.frame_idx), 0);

      // One-shot play at (100,200).
      bus.sprite_x = 10'd100; bus.sprite_y = 10'd200; bus.anim_loop = 1'b0;
      bus.anim_start = 1'b1;
      pix(0, 0, 0);
      done_seen = 0;
      repeat (7) vframe(3, 0);
      check("fb7_frame", 32'(bus.frame_idx), 1);
      repeat (12) vframe(3, 0);
      check("fb19_frame", 32'(bus.frame_idx), 3);
      repeat (6) vframe(3, 0);
      check("oneshot_done_cnt", 32'(done_seen), 1);
      check("hold_frame", 32'(bus.frame_idx), 3);
      check("hold_busy",  32'(bus.anim_busy), 0);

      // Looping play.
      bus.anim_loop = 1'b1;
      bus.anim_start = 1'b1;
      pix(0, 0, 0);
      done_seen = 0;
      repeat (25) vframe(3, 0);
      check("loop_wrap_frame", 32'(bus.frame_idx), 0);
      check("loop_busy",       32'(bus.anim_busy), 1);
      check("loop_no_done",    32'(done_seen),     0);

      // Address on frame 2.
      bus.anim_start = 1'b1;
      pix(0, 0, 0);
      repeat (13) vframe(2, 0);
      pix(110, 210, 1);
      check("addr_f2",    32'(bus.rom_address), 6910);
      check("pv_f2",      32'(bus.pix_valid),   1);
      pix(150, 210, 1);
      check("pv_outside", 32'(bus.pix_valid),   0);
      check("addr_hold",  32'(bus.rom_address), 6910);

      // Bottom-right clipping and borrow.
      bus.sprite_x = 10'd600; bus.sprite_y = 10'd450;
      bus.anim_start = 1'b1;
      vframe(1, 0);
      pix(639, 479, 1);
      check("clip_addr", 32'(bus.rom_address), 1489);
      check("clip_pv",   32'(bus.pix_valid),   1);
      pix(5, 479, 1);
      check("borrow_pv", 32'(bus.pix_valid),   0);
      pix(620, 460, 0);
      check("blank_pv",  32'(bus.pix_valid),   0);

      // Restart coinciding with a frame-advancing boundary; mid-frame move.
      bus.sprite_x = 10'd100; bus.sprite_y = 10'd200;
      bus.anim_start = 1'b1;
      pix(0, 0, 0);
      done_seen = 0;
      repeat (18) vframe(2, 0);
      check("pre_restart_frame", 32'(bus.frame_idx), 2);
      bus.sprite_x = 10'd300;
      pix(110, 210, 1);
      check("old_pos_pv",   32'(bus.pix_valid),   1);
      check("old_pos_addr", 32'(bus.rom_address), 6910);
      bus.anim_start = 1'b1;
      vframe(0, 0);
      check("restart_frame",   32'(bus.frame_idx), 0);
      check("restart_no_done", 32'(done_seen),     0);
      check("restart_busy",    32'(bus.anim_busy), 1);
      pix(310, 210, 1);
      check("new_pos_addr", 32'(bus.rom_address), 510);

      // Randomized traffic.
      repeat (150) vframe(6, 1);

      // Asynchronous reset in the middle of a line.
      bus.vsync = 1'b0;
      bus.anim_start = 1'b0;
      bus.anim_loop = 1'b1;
      bus.anim_start = 1'b1;
      pix(0, 0, 0);
      repeat (8) vframe(2, 0);
      pix(110, 210, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(negedge vga_clk);
      reset_n = 1'b1;
      repeat (3) vframe(3, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/knight_anim_ctrl.md
Name: knight_anim_ctrl

Overview:
Animation sequencer and ROM address generator for one 50x64 palettized knight sprite strip. The strip holds NUM_FRAMES frames stored back-to-back in one sprite ROM. The block steps the frame index once every TICKS_PER_FRAME video frames. It places the sprite at a screen position latched once per frame, and emits the per-pixel ROM address plus a coverage flag to the pixel mux that feeds the negedge-clocked ROM and palette.

Parameters:
SPR_W, 50, sprite width in pixels
SPR_H, 64, sprite height in pixels
NUM_FRAMES, 4, frames in the ROM strip (>=1)
TICKS_PER_FRAME, 6, video frames each animation frame is shown (>=1)
ADDR_W, 14, ROM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*SPR_W*SPR_H

Ports:
vga_clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video
vsync  in  1  frame sync from VGA controller; its rising edge is the frame boundary
sprite_x  in  10  requested top-left column
sprite_y  in  10  requested top-left row
anim_start  in  1  one-cycle request to (re)start the animation
anim_loop  in  1  1 = wrap to frame 0 after the last frame; 0 = hold the last frame
rom_address  out  ADDR_W  registered ROM address
pix_valid  out  1  registered; 1 = the pixel is inside the sprite box and blank=1
frame_idx  out  $clog2(NUM_FRAMES) (min 1)  current frame
anim_busy  out  1  1 while in PLAY
anim_done  out  1  one-cycle pulse when a one-shot play finishes

Behaviour:
- Reset values (asynchronous, reset_n=0): rom_address=0, pix_valid=0, frame_idx=0, anim_busy=0, anim_done=0, tick counter=0, state=IDLE, latched position=(0,0), start_pending=0, vsync_q=0.
- Frame boundary fb: registered vsync_q; fb = vsync & ~vsync_q, a one-cycle pulse.
- anim_start sets start_pending on any cycle. start_pending clears at the next fb.
- All state, frame_idx and the latched sprite_x/sprite_y update only on fb cycles. This gives tear-free frames.
- States:
  - IDLE: frame_idx=0, not busy.
  - PLAY: animation running.
  - HOLD: one-shot finished; the last frame stays displayed.
- Transitions, evaluated only on fb:
  - start_pending (any state) -> PLAY, frame_idx=0, tick=0. start_pending has priority over every other transition on the same fb.
  - PLAY, tick<TICKS_PER_FRAME-1 -> tick+1.
  - PLAY, tick=TICKS_PER_FRAME-1, frame_idx<NUM_FRAMES-1 -> frame_idx+1, tick=0.
  - PLAY, tick=TICKS_PER_FRAME-1, frame_idx=NUM_FRAMES-1, anim_loop=1 -> frame_idx=0, tick=0.
  - PLAY, tick=TICKS_PER_FRAME-1, frame_idx=NUM_FRAMES-1, anim_loop=0 -> HOLD; anim_done=1 for exactly that cycle.
  - HOLD and IDLE stay put until start_pending is set.
- anim_busy = (state==PLAY), registered with the state.
- Address path (1-cycle latency, registered on posedge vga_clk):
  - dx = DrawX - latched_x and dy = DrawY - latched_y, unsigned 11-bit with borrow.
  - in_box = no borrow on either & dx<SPR_W & dy<SPR_H.
  - rom_address <= frame_idx*SPR_W*SPR_H + dy*SPR_W + dx when in_box; otherwise it holds its previous value.
  - pix_valid <= in_box & blank.
  - Consumers pair rom_address/pix_valid with ROM q at the next posedge. The ROM samples on the negedge between them.
- Boundary cases:
  - Sprite partially off-screen right or bottom: clip naturally; no wrap-around. dx is computed at 11 bits, so 639-600 never aliases.
  - sprite_x > DrawX: the borrow forces in_box=0.
  - NUM_FRAMES=1: frame_idx stays at 0. In a one-shot play, HOLD and anim_done follow after TICKS_PER_FRAME fbs.
  - Mid-play anim_start: restarts from frame 0 at the next fb, with no anim_done.
  - reset_n asserted mid-frame: all outputs go to their reset values immediately. After release the block waits for an fb.
  - Changes to sprite_x/sprite_y mid-frame have no effect until the next fb.

Decomposition:
- Package knight_anim_pkg holds:
  - typedef anim_state_t enum {IDLE, PLAY, HOLD};
  - localparam FRAME_WORDS = SPR_W*SPR_H;
  - helper function calc_addr(frame, dx, dy).
- Sub-module anim_addr_gen holds the box test and address pipeline. It is separate from the FSM/tick logic so it can be reused by other sprites sharing the ROM format.

Test Plan:
- Reset with reset_n=0 mid-line, then release -> all outputs 0, state IDLE. frame_idx stays 0 across 3 fbs with no start.
- sprite=(100,200), anim_start, loop=0, TICKS=6, NUM=4 -> PLAY at fb1; frame_idx increments every 6 fbs (1 at fb7, 3 at fb19). anim_done pulses once at fb25, then HOLD with frame_idx=3, anim_busy=0.
- Same setup with loop=1 -> frame_idx returns to 0 at fb25. No anim_done; anim_busy stays 1.
- frame_idx=2, DrawX=110, DrawY=210, blank=1 -> next cycle rom_address=6400+500+10=6910, pix_valid=1. DrawX=150 -> pix_valid=0 and rom_address holds 6910.
- sprite=(600,450), DrawX=639, DrawY=479, frame 0 -> pix_valid=1, rom_address=29*50+39=1489. DrawX=5 -> pix_valid=0 (borrow). blank=0 inside the box -> pix_valid=0.
- anim_start during frame 2 in the same cycle as an fb that would advance the frame -> frame_idx=0, tick=0, no anim_done. sprite_x changed mid-frame takes effect only at the next fb.
